periph_bus_responder: RTL and testbench



---
 rtl/periph_bus_responder.sv | 168 ++++++++++++++++
 tb/tb_periph_bus_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_responder.sv
// periph_bus_responder
//   Responder end of the core's single-cycle data bus. Decodes the byte
//   address / write data / write strobe driven by the core and returns read
//   data combinationally in the same cycle.
//   Address map (addr[1:0] ignored, word access only):
//     0x0xxx_xxxx  data RAM, DMEM_WORDS x 32 bit, higher index bits alias
//     0x1xxx_xx00  GPIO_OUT   rw
//     0x1xxx_xx04  GPIO_IN    ro  (2-flop synchronised gpio_i)
//     0x1xxx_xx08  PWM_PERIOD rw
//     0x1xxx_xx0C  PWM0_DUTY  rw
//     0x1xxx_xx10  PWM1_DUTY  rw
//     0x1xxx_xx14  MOTOR_DIR  rw  bits[1:0]
//     0x1xxx_xx18  TIMER      read count, any write clears
//   Anything else reads 0 and ignores writes.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_addr_i/wdata_i/wen_i core data bus request
//   mem_rdata_o             combinational read data
//   gpio_i / gpio_o         board inputs / registered LED outputs
//   pwm_o                   registered motor PWM, bit0 left, bit1 right
//   dir_o                   registered motor direction bits
module periph_bus_responder #(
   parameter int unsigned DMEM_WORDS = 1024,
   parameter int unsigned PWM_W      = 16,
   parameter int unsigned GPIO_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   input  logic              mem_wen_i,
   output logic [31:0]       mem_rdata_o,
   input  logic [GPIO_W-1:0] gpio_i,
   output logic [GPIO_W-1:0] gpio_o,
   output logic [1:0]        pwm_o,
   output logic [1:0]        dir_o
);

   localparam int unsigned AW = $clog2(DMEM_WORDS);

   typedef enum logic [5:0] {
      REG_GPIO_OUT   = 6'h00,
      REG_GPIO_IN    = 6'h01,
      REG_PWM_PERIOD = 6'h02,
      REG_PWM0_DUTY  = 6'h03,
      REG_PWM1_DUTY  = 6'h04,
      REG_MOTOR_DIR  = 6'h05,
      REG_TIMER      = 6'h06
   } reg_word_e;

   // Decode
   logic          is_ram;
   logic          is_reg;
   logic [5:0]    word_off;
   logic [AW-1:0] ram_idx;
   logic          ram_we;
   logic          wr_gpio, wr_period, wr_duty0, wr_duty1, wr_dir, wr_timer;
   logic          unused_addr_bits;

   assign is_ram   = (mem_addr_i[31:28] == 4'h0);
   assign is_reg   = (mem_addr_i[31:28] == 4'h1);
   assign word_off = mem_addr_i[7:2];
   assign ram_idx  = mem_addr_i[AW+1:2];
   assign ram_we   = mem_wen_i && is_ram;

   assign wr_gpio   = mem_wen_i && is_reg && (word_off == REG_GPIO_OUT);
   assign wr_period = mem_wen_i && is_reg && (word_off == REG_PWM_PERIOD);
   assign wr_duty0  = mem_wen_i && is_reg && (word_off == REG_PWM0_DUTY);
   assign wr_duty1  = mem_wen_i && is_reg && (word_off == REG_PWM1_DUTY);
   assign wr_dir    = mem_wen_i && is_reg && (word_off == REG_MOTOR_DIR);
   assign wr_timer  = mem_wen_i && is_reg && (word_off == REG_TIMER);

   assign unused_addr_bits = ^{mem_addr_i[27:AW+2], mem_addr_i[1:0]};

   // State
   logic [31:0]       mem_q [DMEM_WORDS];
   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
   logic [GPIO_W-1:0] sync1_q, sync1_d;
   logic [GPIO_W-1:0] sync2_q, sync2_d;
   logic [PWM_W-1:0]  period_q, period_d;
   logic [PWM_W-1:0]  duty0_q, duty0_d;
   logic [PWM_W-1:0]  duty1_q, duty1_d;
   logic [PWM_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        dir_q, dir_d;
   logic [1:0]        pwm_q, pwm_d;
   logic [31:0]       timer_q, timer_d;

   // Data RAM: no reset, contents undefined until written
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem_q[ram_idx] <= mem_wdata_i;
      end
   end

   always_comb begin
      gpio_out_d = wr_gpio   ? mem_wdata_i[GPIO_W-1:0] : gpio_out_q;
      period_d   = wr_period ? mem_wdata_i[PWM_W-1:0]  : period_q;
      duty0_d    = wr_duty0  ? mem_wdata_i[PWM_W-1:0]  : duty0_q;
      duty1_d    = wr_duty1  ? mem_wdata_i[PWM_W-1:0]  : duty1_q;
      dir_d      = wr_dir    ? mem_wdata_i[1:0]        : dir_q;
      timer_d    = wr_timer  ? '0 : timer_q + 32'd1;
      sync1_d    = gpio_i;
      sync2_d    = sync1_q;

      // Counter wraps against the period being committed this edge, so a
      // shrinking period restarts the count at once instead of overrunning.
      if (period_d == '0) begin
         cnt_d = '0;
      end else if (cnt_q >= period_d - PWM_W'(1)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PWM_W'(1);
      end

      pwm_d[0] = (period_q != '0) && (cnt_q < duty0_q);
      pwm_d[1] = (period_q != '0) && (cnt_q < duty1_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         period_q   <= '0;
         duty0_q    <= '0;
         duty1_q    <= '0;
         cnt_q      <= '0;
         dir_q      <= '0;
         pwm_q      <= '0;
         timer_q    <= '0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         period_q   <= period_d;
         duty0_q    <= duty0_d;
         duty1_q    <= duty1_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         pwm_q      <= pwm_d;
         timer_q    <= timer_d;
      end
   end

   // Read mux: current state only, so a same-cycle write reads the old value
   always_comb begin
      mem_rdata_o = '0;
      if (is_ram) begin
         mem_rdata_o = mem_q[ram_idx];
      end else if (is_reg) begin
         case (word_off)
            REG_GPIO_OUT:   mem_rdata_o[GPIO_W-1:0] = gpio_out_q;
            REG_GPIO_IN:    mem_rdata_o[GPIO_W-1:0] = sync2_q;
            REG_PWM_PERIOD: mem_rdata_o[PWM_W-1:0]  = period_q;
            REG_PWM0_DUTY:  mem_rdata_o[PWM_W-1:0]  = duty0_q;
            REG_PWM1_DUTY:  mem_rdata_o[PWM_W-1:0]  = duty1_q;
            REG_MOTOR_DIR:  mem_rdata_o[1:0]        = dir_q;
            REG_TIMER:      mem_rdata_o             = timer_q;
            default:        mem_rdata_o             = '0;
         endcase
      end
   end

   assign gpio_o = gpio_out_q;
   assign pwm_o  = pwm_q;
   assign dir_o  = dir_q;

endmodule

// File: tb/tb_periph_bus_responder.sv
module tb_periph_bus_responder;

  localparam int unsigned DMEM_WORDS = 1024;
  localparam int unsigned PWM_W      = 16;
  localparam int unsigned GPIO_W     = 8;

  localparam logic [31:0] A_GPIO_OUT = 32'h1000_0000;
  localparam logic [31:0] A_GPIO_IN  = 32'h1000_0004;
  localparam logic [31:0] A_PERIOD   = 32'h1000_0008;
  localparam logic [31:0] A_DUTY0    = 32'h1000_000C;
  localparam logic [31:0] A_DUTY1    = 32'h1000_0010;
  localparam logic [31:0] A_DIR      = 32'h1000_0014;
  localparam logic [31:0] A_TIMER    = 32'h1000_0018;
  localparam logic [31:0] A_IDLE     = 32'h3000_0000;

  localparam int K_RDATA = 0;
  localparam int K_GPIO  = 1;
  localparam int K_PWM   = 2;
  localparam int K_DIR   = 3;

  logic              clk;
  logic              rst_n;
  logic [31:0]       mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_wen_i;
  logic [31:0]       mem_rdata_o;
  logic [GPIO_W-1:0] gpio_i;
  logic [GPIO_W-1:0] gpio_o;
  logic [1:0]        pwm_o;
  logic [1:0]        dir_o;

  periph_bus_responder #(
    .DMEM_WORDS(DMEM_WORDS),
    .PWM_W     (PWM_W),
    .GPIO_W    (GPIO_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_wen_i  (mem_wen_i),
    .mem_rdata_o(mem_rdata_o),
    .gpio_i     (gpio_i),
    .gpio_o     (gpio_o),
    .pwm_o      (pwm_o),
    .dir_o      (dir_o)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    chk_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_RDATA: act = mem_rdata_o;
        K_GPIO:  act = {{(32-GPIO_W){1'b0}}, gpio_o};
        K_PWM:   act = {30'b0, pwm_o};
        default: act = {30'b0, dir_o};
      endcase
      n_cmp++;
      if (e.cyc != cyc || act !== e.val) begin
        n_bad++;
        $display("FAIL %s: cycle %0d got 0x%08h, expected 0x%08h (due cycle %0d)",
                 e.name, cyc, act, e.val, e.cyc);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(posedge clk);
    #1;
    mem_addr_i  = a;
    mem_wdata_i = d;
    mem_wen_i   = w;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] v, input string nm);
    chk_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_v, input string nm);
    drive(a, 32'h0, 1'b0);
    expect_val(K_RDATA, exp_v, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 1'b1);
  endtask

  task automatic idle();
    drive(A_IDLE, 32'h0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e0, e1;
    rst_n       = 1'b0;
    mem_addr_i  = A_IDLE;
    mem_wdata_i = 32'h0;
    mem_wen_i   = 1'b0;
    gpio_i      = '0;

    repeat (2) @(posedge clk);
    rd(A_GPIO_OUT, 32'h0, "rst_gpio_out_rd");
    expect_val(K_GPIO, 32'h0, "rst_gpio_o");
    expect_val(K_PWM,  32'h0, "rst_pwm_o");
    expect_val(K_DIR,  32'h0, "rst_dir_o");

    drive(A_TIMER, 32'h0, 1'b0);
    rst_n = 1'b1;
    expect_val(K_RDATA, 32'd0, "timer_at_release");
    for (int i = 1; i <= 99; i++) idle();
    rd(A_TIMER, 32'd100, "timer_100");
    drive(A_TIMER, 32'h0000_CAFE, 1'b1);
    expect_val(K_RDATA, 32'd101, "timer_wr_cycle_old");
    rd(A_TIMER, 32'd0, "timer_cleared");
    #1;
    n_cmp++;
    if (mem_rdata_o !== 32'd0) begin
      n_bad++;
      $display("FAIL timer_cleared_direct: got 0x%08h, expected 0x%08h", mem_rdata_o, 32'd0);
    end
    rd(A_TIMER, 32'd1, "timer_resume1");
    rd(A_TIMER, 32'd2, "timer_resume2");

    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    #1;
    n_cmp++;
    if (mem_rdata_o !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL ram_rd_direct: got 0x%08h, expected 0x%08h", mem_rdata_o, 32'hDEAD_BEEF);
    end
    rd(32'h0000_0010 + DMEM_WORDS * 4, 32'hDEAD_BEEF, "ram_alias");
    drive(32'h0000_0010, 32'h1234_5678, 1'b1);
    expect_val(K_RDATA, 32'hDEAD_BEEF, "ram_same_cycle_old");
    rd(32'h0000_0010, 32'h1234_5678, "ram_new");
    wr(32'h0000_0000, 32'h1111_1111);
    rd(32'h0000_0000, 32'h1111_1111, "ram_word0");
    rd(32'h0000_0012, 32'h1234_5678, "ram_low_bits_ignored");

    drive(A_GPIO_OUT, 32'h0000_01A5, 1'b1);
    expect_val(K_RDATA, 32'h0, "gpio_same_cycle_old");
    expect_val(K_GPIO,  32'h0, "gpio_o_before_edge");
    rd(A_GPIO_OUT, 32'h0000_00A5, "gpio_rd");
    expect_val(K_GPIO, 32'h0000_00A5, "gpio_o_after");
    #1;
    n_cmp++;
    if (gpio_o !== 8'hA5 || mem_rdata_o !== 32'h0000_00A5) begin
      n_bad++;
      $display("FAIL gpio_direct: got gpio_o 0x%02h rdata 0x%08h, expected 0xa5 / 0x000000a5",
               gpio_o, mem_rdata_o);
    end

    wr(A_DIR, 32'hFFFF_FFFE);
    rd(A_DIR, 32'h2, "dir_rd");
    expect_val(K_DIR, 32'h2, "dir_o");
    #1;
    n_cmp++;
    if (dir_o !== 2'b10) begin
      n_bad++;
      $display("FAIL dir_direct: got %b, expected 10", dir_o);
    end

    wr(A_GPIO_IN, 32'hFFFF_FFFF);
    rd(A_GPIO_IN, 32'h0, "gpio_in_ro");
    rd(A_GPIO_IN, 32'h0, "gpio_in_e0");
    gpio_i = 8'h08;
    rd(A_GPIO_IN, 32'h0, "gpio_in_e1");
    rd(A_GPIO_IN, 32'h8, "gpio_in_e2");
    gpio_i = 8'h00;
    rd(A_GPIO_IN, 32'h8, "gpio_in_fall_e1");
    rd(A_GPIO_IN, 32'h0, "gpio_in_fall_e2");

    rd(32'h1000_0040, 32'h0, "unmapped_reg_rd");
    rd(32'h2000_0000, 32'h0, "unmapped_region_rd");
    rd(32'h1000_001C, 32'h0, "unmapped_off_rd");
    wr(32'h1000_0040, 32'hFFFF_FFFF);
    wr(32'h2000_0000, 32'hFFFF_FFFF);
    wr(32'h1000_001C, 32'h5555_5555);
    rd(32'h0000_0000, 32'h1111_1111, "unmapped_ram_kept");
    rd(A_GPIO_OUT, 32'h0000_00A5, "unmapped_gpio_kept");
    expect_val(K_GPIO, 32'h0000_00A5, "unmapped_gpio_o_kept");
    rd(A_DIR, 32'h2, "unmapped_dir_kept");
    rd(A_PERIOD, 32'h0, "unmapped_period_kept");
    rd(32'h1000_0040, 32'h0, "unmapped_reg_rd_after");

    wr(A_DUTY0, 32'd3);
    wr(A_DUTY1, 32'd10);
    rd(A_DUTY0, 32'd3, "duty0_rd");
    wr(A_PERIOD, 32'd10);
    for (int m = 1; m <= 20; m++) begin
      idle();
      e0 = (m >= 2) && (((m - 1) % 10) < 3);
      e1 = (m >= 2);
      expect_val(K_PWM, {30'b0, e1, e0}, $sformatf("pwm_p10_m%0d", m));
    end
    wr(A_PERIOD, 32'd0);
    idle();
    idle();
    expect_val(K_PWM, 32'h0, "pwm_period0_a");
    idle();
    expect_val(K_PWM, 32'h0, "pwm_period0_b");

    wr(A_DUTY0, 32'd1);
    wr(A_PERIOD, 32'd10);
    for (int m = 1; m <= 7; m++) idle();
    wr(A_PERIOD, 32'd5);
    for (int j = 9; j <= 20; j++) begin
      idle();
      e0 = (j >= 10) && (((j - 10) % 5) == 0);
      expect_val(K_PWM, {30'b0, 1'b1, e0}, $sformatf("pwm_shrink_j%0d", j));
    end

    idle();
    #2;
    rst_n = 1'b0;
    expect_val(K_GPIO, 32'h0, "midrst_gpio_o");
    expect_val(K_PWM,  32'h0, "midrst_pwm_o");
    expect_val(K_DIR,  32'h0, "midrst_dir_o");
    idle();
    drive(A_GPIO_OUT, 32'h0000_003C, 1'b1);
    rst_n = 1'b1;
    expect_val(K_RDATA, 32'h0, "midrst_gpio_old");
    rd(A_GPIO_OUT, 32'h0000_003C, "midrst_first_write");
    expect_val(K_GPIO, 32'h0000_003C, "midrst_gpio_o");
    #1;
    n_cmp++;
    if (gpio_o !== 8'h3C) begin
      n_bad++;
      $display("FAIL midrst_gpio_direct: got 0x%02h, expected 0x3c", gpio_o);
    end
    rd(A_PERIOD, 32'h0, "midrst_period");
    rd(A_TIMER, 32'd3, "midrst_timer");
    rd(32'h0000_0010, 32'h1234_5678, "midrst_ram_kept");

    idle();
    repeat (2) @(posedge clk);
    while (sb.size() > 0) begin
      chk_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never compared, expected 0x%08h", e.name, e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
